// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: state encodings, the default
// starvation bound and the width helper for the starvation counter.
package mem_port_arbiter_pkg;

    localparam int STARVE_LIMIT_DEFAULT = 4;

    localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
    localparam logic [1:0] ST_BUSY_IF_ENC  = 2'd1;
    localparam logic [1:0] ST_BUSY_MEM_ENC = 2'd2;
    localparam logic [1:0] ST_RESP_ENC     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = ST_IDLE_ENC,
        ST_BUSY_IF  = ST_BUSY_IF_ENC,
        ST_BUSY_MEM = ST_BUSY_MEM_ENC,
        ST_RESP     = ST_RESP_ENC
    } arb_state_e;

    // The counter must be able to hold the limit value itself.
    function automatic int starve_cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive data grants made while a fetch is waiting.
// Clear has priority over increment.
module mem_arb_starve_cnt #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single external memory port between instruction fetch and data
// access, one transaction at a time, data first with a starvation bound for fetch.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    input  logic                    if_cancel,
    output logic                    if_done,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    mem_req,
    input  logic                    mem_we,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_be,
    output logic                    mem_done,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    ext_req,
    output logic                    ext_we,
    output logic [ADDR_WIDTH-1:0]   ext_addr,
    output logic [DATA_WIDTH-1:0]   ext_wdata,
    output logic [DATA_WIDTH/8-1:0] ext_be,
    input  logic                    ext_ack,
    input  logic [DATA_WIDTH-1:0]   ext_rdata
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = starve_cnt_width(STARVE_LIMIT);

    arb_state_e state_q, state_d;
    logic       drop_q, drop_d;
    logic       ext_req_q, ext_req_d;
    logic       ext_we_q, ext_we_d;
    logic [ADDR_WIDTH-1:0] ext_addr_q, ext_addr_d;
    logic [DATA_WIDTH-1:0] ext_wdata_q, ext_wdata_d;
    logic [BE_W-1:0]       ext_be_q, ext_be_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
    logic       if_done_q, if_done_d;
    logic       mem_done_q, mem_done_d;

    logic             in_idle;
    logic             fetch_live;
    logic             starved;
    logic             grant_if;
    logic             grant_mem;
    logic             cnt_inc;
    logic             cnt_clr;
    logic [CNT_W-1:0] starve_cnt;

    // A cancelled fetch is invisible to arbitration for that cycle.
    always_comb begin
        in_idle    = (state_q == ST_IDLE);
        fetch_live = if_req & ~if_cancel;
        grant_if   = in_idle & fetch_live & (~mem_req | starved);
        grant_mem  = in_idle & mem_req & ~grant_if;
        cnt_inc    = grant_mem & fetch_live;
        cnt_clr    = in_idle & (grant_if | ~if_req);
    end

    mem_arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .cnt   (starve_cnt),
        .sat   (starved)
    );

    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        ext_req_d   = ext_req_q;
        ext_we_d    = ext_we_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        ext_be_d    = ext_be_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_mem) begin
                    state_d     = ST_BUSY_MEM;
                    ext_req_d   = 1'b1;
                    ext_we_d    = mem_we;
                    ext_addr_d  = mem_addr;
                    ext_wdata_d = mem_wdata;
                    ext_be_d    = mem_be;
                end else if (grant_if) begin
                    state_d     = ST_BUSY_IF;
                    ext_req_d   = 1'b1;
                    ext_we_d    = 1'b0;
                    ext_addr_d  = if_addr;
                    ext_wdata_d = '0;
                    ext_be_d    = '1;
                end
            end

            // A cancel seen in the ack cycle still kills the response.
            ST_BUSY_IF: begin
                if (if_cancel) begin
                    drop_d = 1'b1;
                end
                if (ext_ack) begin
                    ext_req_d = 1'b0;
                    drop_d    = 1'b0;
                    if (drop_q || if_cancel) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_RESP;
                        if_rdata_d = ext_rdata;
                        if_done_d  = 1'b1;
                    end
                end
            end

            ST_BUSY_MEM: begin
                if (ext_ack) begin
                    ext_req_d  = 1'b0;
                    state_d    = ST_RESP;
                    mem_done_d = 1'b1;
                    if (!ext_we_q) begin
                        mem_rdata_d = ext_rdata;
                    end
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            drop_q      <= 1'b0;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            ext_be_q    <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            ext_req_q   <= ext_req_d;
            ext_we_q    <= ext_we_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            ext_be_q    <= ext_be_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign ext_req   = ext_req_q;
    assign ext_we    = ext_we_q;
    assign ext_addr  = ext_addr_q;
    assign ext_wdata = ext_wdata_q;
    assign ext_be    = ext_be_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_done   = if_done_q;
    assign mem_done  = mem_done_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external memory port between the instruction-fetch stage and the memory-access stage of the five-stage pipeline. It serialises requests through a one-outstanding-transaction FSM and gives data accesses priority, with a starvation bound for fetch. It drops fetches cancelled by a taken branch. It produces the `if_done` / `mem_done` pulses from which the pipeline controller derives `fetch_done` / `mem_done`.

## Interface
- `DATA_WIDTH`, 32, data bus width.
- `ADDR_WIDTH`, 32, byte address width.
- `STARVE_LIMIT`, 4, maximum consecutive data grants while a fetch waits.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `if_req`  in  1  fetch request; level, held with stable `if_addr` until `if_done` or cancel.
- `if_addr`  in  ADDR_WIDTH  fetch address.
- `if_cancel`  in  1  flush of the fetch stage (taken branch).
- `if_done`  out  1  one-cycle pulse; `if_rdata` valid.
- `if_rdata`  out  DATA_WIDTH  fetched instruction, registered.
- `mem_req`  in  1  data request; level, held with stable operands until `mem_done`.
- `mem_we`  in  1  1 = write.
- `mem_addr`  in  ADDR_WIDTH  data address.
- `mem_wdata`  in  DATA_WIDTH  write data.
- `mem_be`  in  DATA_WIDTH/8  byte enables.
- `mem_done`  out  1  one-cycle pulse.
- `mem_rdata`  out  DATA_WIDTH  load data, registered.
- `ext_req`, `ext_we`, `ext_addr`, `ext_wdata`, `ext_be`  out  1/1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  external port; all registered and stable while `ext_req` is high.
- `ext_ack`  in  1  one-cycle completion pulse; `ext_rdata` valid in the same cycle.
- `ext_rdata`  in  DATA_WIDTH  read data.

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_MEM, RESP.
- IDLE, arbitration:
  - `mem_req` is granted over `if_req`.
  - Exception: `if_req` is granted when `starve_cnt == STARVE_LIMIT`.
  - `if_req` is ignored in any cycle where `if_cancel` is high.
- On a grant, the FSM moves to BUSY_x and loads the `ext_*` registers with `ext_req = 1`.
- Starvation counter:
  - Increments on each data grant made while `if_req` is high and `if_cancel` is low.
  - Saturates at `STARVE_LIMIT`.
  - Clears on any fetch grant, and whenever `if_req` is low in IDLE.
- BUSY_x waits for `ext_ack`. `ext_req` drops on the edge after the ack. The captured `ext_rdata` goes to `if_rdata` (fetch) or `mem_rdata` (load only). Writes leave `mem_rdata` unchanged.
- BUSY_x transitions on `ext_ack`:
  - BUSY_MEM → RESP.
  - BUSY_IF → RESP, unless the drop flag is set; then BUSY_IF → IDLE with no `if_done`.
- Drop flag: set by `if_cancel` high in any BUSY_IF cycle, including the ack cycle. Cleared on leaving BUSY_IF.
- RESP: the matching done output is high for exactly one cycle, then the FSM returns to IDLE. Requests are not sampled in RESP.
- `if_cancel` during RESP is ignored; the pipeline flush discards the instruction.
- A request still high in the IDLE cycle after RESP is a new transaction.

## Timing
- Reset values: `ext_req = 0`, `if_done = 0`, `mem_done = 0`, `ext_*`/`*_rdata` = 0, state = IDLE, `starve_cnt = 0`, drop = 0.
- Request high in IDLE at cycle 0:
  - `ext_req` high from cycle 1.
  - If `ext_ack` arrives in cycle k ≥ 1, done is high in cycle k+1 and IDLE resumes at k+2.
- Minimum request-to-done latency: 2 cycles. Maximum throughput: one transaction per 3 cycles.
- `ext_ack` is honoured only in BUSY states; an ack in IDLE/RESP is ignored.
- Reset mid-transaction drops `ext_req` asynchronously. The external memory must tolerate an abandoned request.
- `if_done` and `mem_done` are never high in the same cycle.

## Structure
- The shared package/header holds state encodings (2-bit localparams) and the `STARVE_LIMIT` default.
- Sub-module `mem_arb_starve_cnt`: saturating counter with clear, width `$clog2(STARVE_LIMIT+1)`.
- Estimated size: ~200 lines.

## Test plan
- Fetch only: `if_req=1`, `if_addr=0x100`, ack at cycle 1 with `0x8C010004` → `if_done` at cycle 2, `if_rdata=0x8C010004`, `ext_req` low at cycle 2.
- Simultaneous `if_req` (`0x104`) and `mem_req` (load `0x2000`) → `ext_addr=0x2000` first, `mem_done` first; fetch issued in the IDLE cycle after RESP.
- Starvation: `mem_req` held continuously with `if_req` high, `STARVE_LIMIT=4` → the 5th grant is the fetch, then the counter returns to 0.
- Cancel: `if_cancel` pulsed at cycle 2 of a fetch with ack at cycle 4 → no `if_done`, IDLE at cycle 5, `if_rdata` unchanged.
- Write: `mem_we=1`, `mem_be=4'b0011`, `mem_wdata=0xDEADBEEF` → `ext_we=1`, `ext_be=0011` held until ack; `mem_done` pulses; `mem_rdata` keeps its prior value.
- `rst_n` low while in BUSY_MEM → `ext_req=0` immediately; after release, all outputs are 0 and the FSM is in IDLE.
